ulpi_link: RTL
==============

// Module: ulpi_link
// PURPOSE
//  ULPI link-side controller: owns ulpi_data_out/ulpi_stp and interprets ulpi_dir/ulpi_nxt/ulpi_data_in.
//  Converts PHY register accesses, RX CMD / RX data, and USB TX packets into simple valid/ack streams
//  for the USB core above. Sits directly between the PHY pins (or the PHY bus-functional model) and the core.
// PARAMETERS
//  REG_RETRY_MAX  4   register aborts tolerated before completing with reg_err=1 (0 = retry forever)
// PORTS
//  ulpi_clk       in   1  60 MHz PHY clock; only clock
//  ulpi_rst       in   1  synchronous, active-high reset
//  ulpi_dir       in   1  PHY owns bus when 1
//  ulpi_nxt       in   1  PHY throttle / RX data strobe
//  ulpi_data_in   in   8  bus data from PHY
//  ulpi_stp       out  1  link stop strobe
//  ulpi_data_out  out  8  bus data to PHY
//  reg_req        in   1  register access request; held until reg_ack
//  reg_we         in   1  1 = write, 0 = read
//  reg_addr       in   8  PHY register address
//  reg_wdata      in   8  write data
//  reg_ack        out  1  one-cycle completion pulse
//  reg_rdata      out  8  read data, valid with reg_ack
//  reg_err        out  1  with reg_ack: retries exhausted, no access done
//  tx_valid/tx_ready in/out 1/1  TX byte handshake; first byte = PID
//  tx_data        in   8  TX byte
//  tx_last        in   1  marks final TX byte
//  rx_valid       out  1  one-cycle pulse per received byte
//  rx_data        out  8  received byte
//  rx_active      out  1  RxActive from last RX CMD (forced 1 while dir&nxt data)
//  rx_error       out  1  RxError from last RX CMD
//  line_state     out  2  LineState from last RX CMD
//  vbus_state     out  2  VbusState from last RX CMD
//  host_disc      out  1  HostDisconnect from last RX CMD
// BEHAVIOUR
//  Reset: all outputs 0, ulpi_data_out=8'h00, FSM IDLE. Link drives nothing but 00 while ulpi_dir=1.
//  Turnaround: first cycle after any ulpi_dir edge is ignored for data; link drives 00 in it.
//  dir=1 after turnaround: nxt=1 -> rx_valid, rx_data=ulpi_data_in; nxt=0 -> RX CMD decode:
//   [1:0] line_state, [3:2] vbus_state, [5:4] 00 idle,01 active,11 error(rx_active=1),10 host_disc.
//   dir rising with nxt=1 = RX start (rx_active=1 immediately, no RX CMD).
//  FSM: IDLE, TX_CMD, TX_DATA, TX_STP, REG_CMD, REG_EXT, REG_WDATA, REG_STP, REG_TURN, REG_RDATA, BUS_PHY.
//  Arbitration in IDLE (dir=0): pending reg_req beats tx_valid. PHY dir=1 overrides everything -> BUS_PHY.
//  Reg write: REG_CMD drives 8'h80|addr[5:0] until nxt; REG_WDATA drives wdata until nxt;
//   REG_STP: stp=1, data 00 one cycle; reg_ack same cycle.
//  Reg read: REG_CMD drives 8'hC0|addr[5:0] until nxt; REG_TURN waits dir=1 turnaround;
//   REG_RDATA samples ulpi_data_in -> reg_rdata, reg_ack. Latency min 4 cycles write, 4 read.
//  Abort: dir rising in any REG_* state before ack -> BUS_PHY, request kept, retry count +1, reissue
//   from REG_CMD once dir=0 plus turnaround. Count reaching REG_RETRY_MAX -> reg_ack+reg_err, count clears.
//  TX: TX_CMD drives 8'h40|tx_data[3:0] until nxt (tx_ready=nxt for PID byte); TX_DATA drives tx_data,
//   tx_ready=nxt; byte consumed on tx_valid&tx_ready; after consuming tx_last -> TX_STP (stp=1, 00), IDLE.
//   tx_valid low in TX_DATA: keep driving last byte (underrun is a core bug, not handled).
//   dir rising during TX: abandon packet, drain tx_* until tx_last consumed (tx_ready=1), no stp.
//  ulpi_rst mid-operation: immediate return to reset values; pending req is dropped, no ack.
// CONFIGURATION
//  ULPI_EXT_REG_EN defined: addr>8'h3F or addr==8'h2F uses extended form: REG_CMD sends 8'hAF (write)
//   / 8'hEF (read), REG_EXT sends full reg_addr until nxt, then continues as above (+1 cycle latency).
//  Undefined: REG_EXT absent, reg_addr[7:6] ignored, 6-bit immediate form only.
// STRUCTURE
//  Shared package ulpi_pkg: TXCMD codes (8'h40/80/C0/AF/EF), RX CMD field positions, rxevent encodings,
//   FSM state enum. Sub-module ulpi_rxcmd_dec (turnaround tracking + RX CMD/data decode) is natural;
//   main FSM in ulpi_link.
// TESTING (against the PHY bus-functional model)
//  Write addr 0x0A data 0x45 -> PHY register[0x0A]=0x45, one reg_ack, reg_err=0, stp one cycle.
//  Read addr 0x0A after above -> reg_ack with reg_rdata=0x45.
//  ULPI_EXT_REG_EN: write 0x81 data 0x3C, read back -> 0xAF,0x81 seen on bus; reg_rdata=0x3C.
//  PHY aborts reg write with 8-byte RX -> 8 rx_valid pulses, then write retried and acked once.
//  RX CMD 8'h1D -> line_state=01, vbus_state=11, rx_active=1; then 8'h0D -> rx_active=0.
//  TX PID 0xC3 + 3 bytes -> bus 0x43 then 3 data bytes, stp on following cycle, 4 tx handshakes.

Source files
------------

// File: rtl/ulpi_pkg.sv
// ulpi_pkg: shared ULPI link constants, RX CMD field layout and link FSM state encoding.
package ulpi_pkg;

  localparam logic [7:0] TXCMD_TX   = 8'h40;
  localparam logic [7:0] TXCMD_REGW = 8'h80;
  localparam logic [7:0] TXCMD_REGR = 8'hC0;
  localparam logic [7:0] TXCMD_EXTW = 8'hAF;
  localparam logic [7:0] TXCMD_EXTR = 8'hEF;

  localparam int RXCMD_LS_LSB   = 0;
  localparam int RXCMD_VBUS_LSB = 2;
  localparam int RXCMD_EV_LSB   = 4;

  typedef enum logic [1:0] {
    RXEV_IDLE     = 2'b00,
    RXEV_ACTIVE   = 2'b01,
    RXEV_HOSTDISC = 2'b10,
    RXEV_ERROR    = 2'b11
  } rxevent_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_TX_CMD,
    ST_TX_DATA,
    ST_TX_STP,
    ST_REG_CMD,
    ST_REG_EXT,
    ST_REG_WDATA,
    ST_REG_STP,
    ST_REG_TURN,
    ST_REG_RDATA,
    ST_BUS_PHY
  } state_e;

endpackage

// File: rtl/ulpi_if.sv
// ulpi_if: ULPI pin bundle plus the register, TX and RX streams toward the USB core.
interface ulpi_if;
  logic       ulpi_dir;
  logic       ulpi_nxt;
  logic [7:0] ulpi_data_in;
  logic       ulpi_stp;
  logic [7:0] ulpi_data_out;

  logic       reg_req;
  logic       reg_we;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_ack;
  logic [7:0] reg_rdata;
  logic       reg_err;

  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_last;

  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_active;
  logic       rx_error;
  logic [1:0] line_state;
  logic [1:0] vbus_state;
  logic       host_disc;

  modport master (
    input  ulpi_dir, ulpi_nxt, ulpi_data_in,
    output ulpi_stp, ulpi_data_out,
    input  reg_req, reg_we, reg_addr, reg_wdata,
    output reg_ack, reg_rdata, reg_err,
    input  tx_valid, tx_data, tx_last,
    output tx_ready,
    output rx_valid, rx_data, rx_active, rx_error, line_state, vbus_state, host_disc
  );

  modport slave (
    output ulpi_dir, ulpi_nxt, ulpi_data_in,
    input  ulpi_stp, ulpi_data_out,
    output reg_req, reg_we, reg_addr, reg_wdata,
    input  reg_ack, reg_rdata, reg_err,
    output tx_valid, tx_data, tx_last,
    input  tx_ready,
    input  rx_valid, rx_data, rx_active, rx_error, line_state, vbus_state, host_disc
  );
endinterface

// File: rtl/ulpi_rxcmd_dec.sv
// ulpi_rxcmd_dec: tracks bus turnaround and decodes PHY-driven cycles into RX bytes
// and RX CMD status fields.
module ulpi_rxcmd_dec
  import ulpi_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_dir,
  input  logic       i_nxt,
  input  logic [7:0] i_data,
  input  logic       i_rd_cyc,
  output logic       o_turn,
  output logic       o_dir_rise,
  output logic       o_rx_valid,
  output logic [7:0] o_rx_data,
  output logic       o_rx_active,
  output logic       o_rx_error,
  output logic [1:0] o_line_state,
  output logic [1:0] o_vbus_state,
  output logic       o_host_disc
);

  logic     r_dir_q;
  rxevent_e w_ev;
  logic     w_unused_id;

  assign o_turn      = i_dir ^ r_dir_q;
  assign o_dir_rise  = i_dir & ~r_dir_q;
  assign w_ev        = rxevent_e'(i_data[RXCMD_EV_LSB +: 2]);
  assign w_unused_id = ^i_data[7:6];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dir_q      <= 1'b0;
      o_rx_valid   <= 1'b0;
      o_rx_data    <= 8'h00;
      o_rx_active  <= 1'b0;
      o_rx_error   <= 1'b0;
      o_line_state <= 2'b00;
      o_vbus_state <= 2'b00;
      o_host_disc  <= 1'b0;
    end else begin
      r_dir_q    <= i_dir;
      o_rx_valid <= 1'b0;
      // A register-read data cycle looks like an RX CMD on the pins; skip it.
      if (i_dir && !o_turn && !i_rd_cyc) begin
        if (i_nxt) begin
          o_rx_valid  <= 1'b1;
          o_rx_data   <= i_data;
          o_rx_active <= 1'b1;
        end else begin
          o_line_state <= i_data[RXCMD_LS_LSB +: 2];
          o_vbus_state <= i_data[RXCMD_VBUS_LSB +: 2];
          o_rx_active  <= (w_ev == RXEV_ACTIVE) || (w_ev == RXEV_ERROR);
          o_rx_error   <= (w_ev == RXEV_ERROR);
          o_host_disc  <= (w_ev == RXEV_HOSTDISC);
        end
      end else if (o_dir_rise && i_nxt) begin
        o_rx_active <= 1'b1;
      end else if (!i_dir && r_dir_q) begin
        // PHY releasing the bus ends any receive in progress.
        o_rx_active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ulpi_link.sv
// ulpi_link: ULPI link-side controller (register access, TX packets, RX decode).
// Define ULPI_EXT_REG_EN to enable extended register addressing (REG_EXT state).
module ulpi_link
  import ulpi_pkg::*;
#(
  parameter int unsigned REG_RETRY_MAX = 4
) (
  input logic    i_ulpi_clk,
  input logic    i_ulpi_rst,
  ulpi_if.master bus
);

  localparam logic [7:0] RETRY_LIM = 8'(REG_RETRY_MAX);

  state_e     r_state;
  state_e     w_next;
  logic       w_abort;
  logic [7:0] r_retry;
  logic       r_drain;
  logic [7:0] r_tx_hold;
  logic       w_retry_last;
  logic       w_ext;
  logic [7:0] w_drive;
  logic       w_stp;
  logic       w_ack;
  logic       w_err;
  logic [7:0] w_rdata;
  logic       w_tx_ready;

  logic       w_turn;
  logic       w_dir_rise;
  logic       w_rx_valid;
  logic [7:0] w_rx_data;
  logic       w_rx_active;
  logic       w_rx_error;
  logic [1:0] w_line_state;
  logic [1:0] w_vbus_state;
  logic       w_host_disc;

`ifdef ULPI_EXT_REG_EN
  assign w_ext = (bus.reg_addr > 8'h3F) || (bus.reg_addr == 8'h2F);
`else
  logic w_unused_addr;
  assign w_ext         = 1'b0;
  assign w_unused_addr = ^bus.reg_addr[7:6];
`endif

  assign w_retry_last = (RETRY_LIM != 8'd0) && ((r_retry + 8'd1) == RETRY_LIM);

  ulpi_rxcmd_dec u_dec (
    .i_clk        (i_ulpi_clk),
    .i_rst        (i_ulpi_rst),
    .i_dir        (bus.ulpi_dir),
    .i_nxt        (bus.ulpi_nxt),
    .i_data       (bus.ulpi_data_in),
    .i_rd_cyc     (r_state == ST_REG_RDATA),
    .o_turn       (w_turn),
    .o_dir_rise   (w_dir_rise),
    .o_rx_valid   (w_rx_valid),
    .o_rx_data    (w_rx_data),
    .o_rx_active  (w_rx_active),
    .o_rx_error   (w_rx_error),
    .o_line_state (w_line_state),
    .o_vbus_state (w_vbus_state),
    .o_host_disc  (w_host_disc)
  );

  always_ff @(posedge i_ulpi_clk) begin
    if (i_ulpi_rst) r_state <= ST_IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_abort = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.ulpi_dir)                      w_next = ST_BUS_PHY;
        else if (!w_turn && bus.reg_req)       w_next = ST_REG_CMD;
        else if (!w_turn && bus.tx_valid && !r_drain) w_next = ST_TX_CMD;
      end
      ST_TX_CMD: begin
        if (w_dir_rise)                        w_next = ST_BUS_PHY;
        else if (bus.ulpi_nxt && bus.tx_valid) w_next = bus.tx_last ? ST_TX_STP : ST_TX_DATA;
      end
      ST_TX_DATA: begin
        if (w_dir_rise)                        w_next = ST_BUS_PHY;
        else if (bus.ulpi_nxt && bus.tx_valid && bus.tx_last) w_next = ST_TX_STP;
      end
      ST_TX_STP:   w_next = ST_IDLE;
      ST_REG_CMD: begin
        if (w_dir_rise)        w_abort = 1'b1;
        else if (bus.ulpi_nxt) w_next = w_ext ? ST_REG_EXT : (bus.reg_we ? ST_REG_WDATA : ST_REG_TURN);
      end
`ifdef ULPI_EXT_REG_EN
      ST_REG_EXT: begin
        if (w_dir_rise)        w_abort = 1'b1;
        else if (bus.ulpi_nxt) w_next = bus.reg_we ? ST_REG_WDATA : ST_REG_TURN;
      end
`endif
      ST_REG_WDATA: begin
        if (w_dir_rise)        w_abort = 1'b1;
        else if (bus.ulpi_nxt) w_next = ST_REG_STP;
      end
      ST_REG_STP:  w_next = ST_IDLE;
      ST_REG_TURN: begin
        // nxt with the turnaround means the PHY started a receive instead of returning data.
        if (w_dir_rise && bus.ulpi_nxt) w_abort = 1'b1;
        else if (w_dir_rise)            w_next = ST_REG_RDATA;
      end
      ST_REG_RDATA: w_next = ST_IDLE;
      ST_BUS_PHY: begin
        if (!bus.ulpi_dir) w_next = ST_IDLE;
      end
      default:     w_next = ST_IDLE;
    endcase
    if (w_abort) w_next = ST_BUS_PHY;
  end

  always_comb begin
    w_drive    = 8'h00;
    w_stp      = 1'b0;
    w_ack      = 1'b0;
    w_err      = 1'b0;
    w_rdata    = 8'h00;
    w_tx_ready = r_drain;
    case (r_state)
      ST_TX_CMD: begin
        w_drive    = TXCMD_TX | {4'h0, bus.tx_data[3:0]};
        w_tx_ready = bus.ulpi_nxt & ~bus.ulpi_dir;
      end
      ST_TX_DATA: begin
        w_drive    = bus.tx_valid ? bus.tx_data : r_tx_hold;
        w_tx_ready = bus.ulpi_nxt & ~bus.ulpi_dir;
      end
      ST_TX_STP:  w_stp = 1'b1;
      ST_REG_CMD: begin
        if (w_ext) w_drive = bus.reg_we ? TXCMD_EXTW : TXCMD_EXTR;
        else       w_drive = (bus.reg_we ? TXCMD_REGW : TXCMD_REGR) | {2'b00, bus.reg_addr[5:0]};
      end
`ifdef ULPI_EXT_REG_EN
      ST_REG_EXT:   w_drive = bus.reg_addr;
`endif
      ST_REG_WDATA: w_drive = bus.reg_wdata;
      ST_REG_STP: begin
        w_stp = 1'b1;
        w_ack = 1'b1;
      end
      ST_REG_RDATA: begin
        w_ack   = 1'b1;
        w_rdata = bus.ulpi_data_in;
      end
      default: ;
    endcase
    if (w_abort && w_retry_last) begin
      w_ack = 1'b1;
      w_err = 1'b1;
    end
  end

  always_ff @(posedge i_ulpi_clk) begin
    if (i_ulpi_rst) begin
      r_retry   <= 8'd0;
      r_drain   <= 1'b0;
      r_tx_hold <= 8'h00;
    end else begin
      if (w_ack)        r_retry <= 8'd0;
      else if (w_abort) r_retry <= r_retry + 8'd1;
      if ((r_state == ST_TX_CMD || r_state == ST_TX_DATA) && w_dir_rise) r_drain <= 1'b1;
      else if (r_drain && bus.tx_valid && bus.tx_last)                     r_drain <= 1'b0;
      r_tx_hold <= w_drive;
    end
  end

  assign bus.ulpi_data_out = (bus.ulpi_dir || w_turn) ? 8'h00 : w_drive;
  assign bus.ulpi_stp      = w_stp;
  assign bus.reg_ack       = w_ack;
  assign bus.reg_err       = w_err;
  assign bus.reg_rdata     = w_rdata;
  assign bus.tx_ready      = w_tx_ready;
  assign bus.rx_valid      = w_rx_valid;
  assign bus.rx_data       = w_rx_data;
  assign bus.rx_active     = w_rx_active;
  assign bus.rx_error      = w_rx_error;
  assign bus.line_state    = w_line_state;
  assign bus.vbus_state    = w_vbus_state;
  assign bus.host_disc     = w_host_disc;

endmodule
